// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state, instruction-class and register constants for the ARM-subset pipeline.
package pipe_pkg;
  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;
  localparam logic [2:0] DP_REG = 3'b000;
  localparam logic [2:0] DP_IMM = 3'b001;
  localparam logic [2:0] LS_IMM = 3'b010;
  localparam logic [2:0] LS_REG = 3'b011;
  localparam logic [2:0] BRANCH = 3'b101;
  localparam logic [3:0] MOV = 4'b1101;
  localparam logic [3:0] MVN = 4'b1111;
  localparam logic [3:0] PC_REG = 4'd15;
  localparam logic [31:0] NOP = 32'h0;
endpackage

// File: rtl/if_id_hazard_stage_if.sv
// if_id_hazard_stage_if: fetch/EXE inputs and decode/control outputs of the IF/ID stage (HAZARD_STATS_EN adds counters).
interface if_id_hazard_stage_if #(parameter int DATA_W = 32, parameter int REG_W = 4);
  logic [DATA_W-1:0] IF_instruction, IF_PC, ID_instruction, ID_PC;
  logic IF_valid, EXE_load, EXE_valid, branch_taken, ID_valid, PC_enable, ID_EXE_bubble, stalled;
  logic [REG_W-1:0] EXE_Rd_num;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif
  modport master (
    output IF_instruction, IF_PC, IF_valid, EXE_Rd_num, EXE_load, EXE_valid, branch_taken,
    input ID_instruction, ID_PC, ID_valid, PC_enable, ID_EXE_bubble, stalled
`ifdef HAZARD_STATS_EN
    , input stall_cnt, flush_cnt
`endif
  );
  modport slave (
    input IF_instruction, IF_PC, IF_valid, EXE_Rd_num, EXE_load, EXE_valid, branch_taken,
    output ID_instruction, ID_PC, ID_valid, PC_enable, ID_EXE_bubble, stalled
`ifdef HAZARD_STATS_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/src_reg_decode.sv
// src_reg_decode: source register numbers and use flags of an instruction (shared with forwarding).
module src_reg_decode import pipe_pkg::*; (
  input  logic [31:0] instr,
  output logic [3:0]  rn,
  output logic [3:0]  rm,
  output logic [3:0]  rd,
  output logic        rn_use,
  output logic        rm_use,
  output logic        rd_use
);
  assign rn = instr[19:16];
  assign rm = instr[3:0];
  assign rd = instr[15:12];
  assign rn_use = !(instr[27:26] == 2'b00 && (instr[24:21] == MOV || instr[24:21] == MVN));
  assign rm_use = instr[27:25] == DP_REG || instr[27:25] == LS_REG;
  // store data register is read, loads write Rd instead
  assign rd_use = instr[27:26] == 2'b01 && !instr[20];
endmodule

// File: rtl/if_id_hazard_stage.sv
// if_id_hazard_stage: IF/ID register with load-use stall, ID/EXE bubble and branch flush.
// Defining HAZARD_STATS_EN adds saturating stall_cnt/flush_cnt outputs.
module if_id_hazard_stage import pipe_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int REG_W = 4,
  parameter logic [REG_W-1:0] PC_REG = pipe_pkg::PC_REG
) (
  input logic clk,
  input logic reset,
  if_id_hazard_stage_if.slave s
);
  state_t state, state_n;
  logic [3:0] rn, rm, rd;
  logic rn_use, rm_use, rd_use, hazard, stall;
  src_reg_decode u_dec (
    .instr(s.ID_instruction[31:0]), .rn(rn), .rm(rm), .rd(rd),
    .rn_use(rn_use), .rm_use(rm_use), .rd_use(rd_use)
  );
  always_comb begin
    hazard = s.ID_valid & s.EXE_valid & s.EXE_load & (s.EXE_Rd_num != PC_REG) &
             ((rn_use & (rn == s.EXE_Rd_num)) | (rm_use & (rm == s.EXE_Rd_num)) | (rd_use & (rd == s.EXE_Rd_num)));
    stall = !reset & !s.branch_taken & (state == RUN) & hazard;
    state_n = stall ? STALL : RUN;
    s.PC_enable = !stall;
    s.ID_EXE_bubble = !reset & (s.branch_taken | stall);
    s.stalled = !reset & (state == STALL);
  end
  always_ff @(posedge clk)
    state <= reset ? RUN : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      s.ID_instruction <= '0;
      s.ID_PC <= '0;
      s.ID_valid <= 1'b0;
    end else if (s.branch_taken) begin
      s.ID_instruction <= DATA_W'(NOP);
      s.ID_valid <= 1'b0;
    end else if (!stall) begin
      s.ID_instruction <= s.IF_instruction;
      s.ID_PC <= s.IF_PC;
      s.ID_valid <= s.IF_valid;
    end
  end
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (s.branch_taken && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end
  assign s.stall_cnt = stall_cnt_q;
  assign s.flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_if_id_hazard_stage.sv
// tb_if_id_hazard_stage: directed and random checks of the IF/ID hazard stage against a behavioural model.
module tb_if_id_hazard_stage;
  logic clk = 1'b0;
  logic reset;
  int n_pass = 0, n_tot = 0;
  if_id_hazard_stage_if #(.DATA_W(32), .REG_W(4)) bus ();
  if_id_hazard_stage dut (.clk(clk), .reset(reset), .s(bus));
  always #5 clk = ~clk;
  logic [31:0] m_instr, m_pc;
  logic m_valid, m_stall;
  int m_scnt, m_fcnt;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  function automatic logic [15:0] src_mask(logic [31:0] i);
    logic [15:0] m = '0;
    int cls = int'(i[27:25]);
    int op = int'(i[24:21]);
    if (!(cls <= 1 && (op == 13 || op == 15))) m[i[19:16]] = 1'b1;
    if (cls == 0 || cls == 3) m[i[3:0]] = 1'b1;
    if ((cls == 2 || cls == 3) && !i[20]) m[i[15:12]] = 1'b1;
    return m;
  endfunction
  function automatic bit model_hz();
    logic [15:0] m = src_mask(m_instr);
    return m_valid && bus.EXE_valid && bus.EXE_load && bus.EXE_Rd_num != 4'd15 && m[bus.EXE_Rd_num] && !m_stall;
  endfunction
  task automatic sample();
    bit h;
    @(negedge clk);
    h = !reset && !bus.branch_taken && model_hz();
    chk("ID_instruction", bus.ID_instruction, m_instr);
    chk("ID_PC", bus.ID_PC, m_pc);
    chk("ID_valid", 32'(bus.ID_valid), 32'(m_valid));
    chk("PC_enable", 32'(bus.PC_enable), 32'(!h));
    chk("ID_EXE_bubble", 32'(bus.ID_EXE_bubble), 32'(!reset && (bus.branch_taken || h)));
    chk("stalled", 32'(bus.stalled), 32'(!reset && m_stall));
`ifdef HAZARD_STATS_EN
    chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_scnt));
    chk("flush_cnt", 32'(bus.flush_cnt), 32'(m_fcnt));
`endif
  endtask
  task automatic adv();
    bit h = model_hz();
    if (reset) begin
      {m_instr, m_pc, m_valid, m_stall, m_scnt, m_fcnt} = '0;
    end else if (bus.branch_taken) begin
      m_instr = 0; m_valid = 0; m_stall = 0;
      if (m_fcnt < 65535) m_fcnt++;
    end else if (h) begin
      m_stall = 1;
      if (m_scnt < 65535) m_scnt++;
    end else begin
      m_instr = bus.IF_instruction; m_pc = bus.IF_PC; m_valid = bus.IF_valid; m_stall = 0;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drive(logic [31:0] ins, logic iv, logic [3:0] rd, logic ld, logic ev, logic br, logic rst);
    bus.IF_instruction = ins; bus.IF_PC = ins ^ 32'h1000; bus.IF_valid = iv;
    bus.EXE_Rd_num = rd; bus.EXE_load = ld; bus.EXE_valid = ev; bus.branch_taken = br; reset = rst;
  endtask
  task automatic one_stall();
    drive(32'hE0831002, 1, 0, 0, 0, 0, 0); sample(); adv();
    drive(32'hE0831002, 1, 3, 1, 1, 0, 0); sample(); adv();
    drive(32'hE0831002, 1, 3, 1, 0, 0, 0); sample(); adv();
  endtask
  initial begin
    logic [31:0] ins;
    drive(0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    {m_instr, m_pc, m_valid, m_stall, m_scnt, m_fcnt} = '0;
    sample();
    chk("reset_pc_en", 32'(bus.PC_enable), 1);
    chk("reset_valid", 32'(bus.ID_valid), 0);
    adv();
    drive(32'hE0831002, 1, 0, 0, 0, 0, 0); sample(); adv();
    drive(32'hE2811001, 1, 3, 1, 1, 0, 0); sample();
    chk("ldu_rn_pc_en", 32'(bus.PC_enable), 0);
    chk("ldu_rn_bubble", 32'(bus.ID_EXE_bubble), 1);
    chk("ldu_rn_hold1", bus.ID_instruction, 32'hE0831002);
    adv();
    drive(32'hE2811001, 1, 3, 1, 0, 0, 0); sample();
    chk("ldu_rn_stalled", 32'(bus.stalled), 1);
    chk("ldu_rn_hold2", bus.ID_instruction, 32'hE0831002);
    adv();
    drive(32'hE1A01003, 1, 0, 0, 0, 0, 0); sample();
    chk("ldu_rn_next", bus.ID_instruction, 32'hE2811001);
    adv();
    drive(32'hE1A01003, 1, 0, 1, 1, 0, 0); sample();
    chk("mov_rn0_no_stall", 32'(bus.PC_enable), 1);
    adv();
    drive(32'hE08F1002, 1, 0, 0, 0, 0, 0); sample(); adv();
    drive(32'hE08F1002, 1, 15, 1, 1, 0, 0); sample();
    chk("pc_reg_no_stall", 32'(bus.ID_EXE_bubble), 0);
    adv();
    drive(32'hE5805000, 1, 0, 0, 0, 0, 0); sample(); adv();
    drive(32'hE5805000, 1, 5, 1, 1, 0, 0); sample();
    chk("str_data_stall", 32'(bus.PC_enable), 0);
    adv();
    drive(32'hE5805000, 1, 5, 1, 0, 0, 0); sample();
    chk("str_stalled", 32'(bus.stalled), 1);
    adv();
    drive(32'hE0831002, 1, 0, 0, 0, 0, 0); sample(); adv();
    drive(32'hE0831002, 1, 3, 1, 1, 1, 0); sample();
    chk("br_pc_en", 32'(bus.PC_enable), 1);
    chk("br_bubble", 32'(bus.ID_EXE_bubble), 1);
    adv();
    drive(32'hE0831002, 1, 0, 0, 0, 0, 0); sample();
    chk("br_flush_valid", 32'(bus.ID_valid), 0);
    chk("br_flush_state", 32'(bus.stalled), 0);
    adv();
    drive(32'hE0831002, 1, 3, 1, 1, 0, 0); sample(); adv();
    drive(32'hE0831002, 1, 3, 1, 0, 0, 1); sample();
    chk("rst_stall_stalled", 32'(bus.stalled), 0);
    adv();
    drive(32'hE2811001, 1, 0, 0, 0, 0, 0); sample();
    chk("rst_stall_clear", bus.ID_instruction, 0);
    chk("rst_stall_run", 32'(bus.stalled), 0);
    adv();
    sample();
    chk("rst_release_load", bus.ID_instruction, 32'hE2811001);
    adv();
`ifdef HAZARD_STATS_EN
    drive(0, 0, 0, 0, 0, 0, 1); sample(); adv();
    for (int k = 0; k < 3; k++) one_stall();
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 0, 1, 0); sample(); adv();
    end
    drive(0, 0, 0, 0, 0, 0, 0); sample();
    chk("stats_stall3", 32'(bus.stall_cnt), 3);
    chk("stats_flush2", 32'(bus.flush_cnt), 2);
    adv();
    force dut.stall_cnt_q = 16'hFFFF;
    #1;
    release dut.stall_cnt_q;
    m_scnt = 65535;
    one_stall();
    sample();
    chk("stats_sat", 32'(bus.stall_cnt), 32'hFFFF);
    adv();
`endif
    for (int c = 0; c < 2000; c++) begin
      ins = $urandom;
      ins[27:25] = 3'($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) ins[24:21] = $urandom_range(0, 1) ? 4'hD : 4'hF;
      ins[19:16] = 4'($urandom_range(0, 7));
      ins[15:12] = 4'($urandom_range(0, 7));
      ins[3:0] = $urandom_range(0, 7) == 0 ? 4'd15 : 4'($urandom_range(0, 7));
      drive(ins, $urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0 ? 4'd15 : 4'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 39) == 0);
      sample();
      adv();
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/if_id_hazard_stage.md
Name: if_id_hazard_stage

Overview:
- IF/ID pipeline register plus load-use hazard control for the 5-stage ARM-subset pipeline.
- Sits upstream of the ID/EXE pipeline register and consumes the signals that register presents to EXE (EXE_Rd_num, load flag, valid).
- Holds the fetched instruction/PC for decode, stalls fetch on load-use, inserts an ID/EXE bubble, and flushes on a taken branch.

Parameters:
- DATA_W, 32, instruction/PC width.
- REG_W, 4, register-number width (r0-r15).
- PC_REG, 15, register number that never causes a hazard (reads return the PC).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high.
- IF_instruction  in  32  fetched instruction.
- IF_PC  in  32  PC+4 of the fetched instruction.
- IF_valid  in  1  fetch slot holds a real instruction.
- EXE_Rd_num  in  4  destination of the instruction now in EXE.
- EXE_load  in  1  EXE instruction is a load (LDR).
- EXE_valid  in  1  EXE slot is not a bubble.
- branch_taken  in  1  EXE resolved a taken branch this cycle.
- ID_instruction  out  32  instruction presented to decode.
- ID_PC  out  32  PC+4 presented to decode.
- ID_valid  out  1  ID slot valid.
- PC_enable  out  1  1 = PC and fetch advance; 0 = hold.
- ID_EXE_bubble  out  1  1 = ID/EXE register loads a NOP (all-zero control, valid=0).
- stalled  out  1  FSM is in STALL (debug).

Behaviour:
- Reset (sync, clk edge with reset=1): ID_instruction=0, ID_PC=0, ID_valid=0, state=RUN. PC_enable=1, ID_EXE_bubble=0, stalled=0 while reset is held.
- Source extraction from ID_instruction:
  - Rn=[19:16] is used unless I_cmd [27:25]=00x and opcode [24:21] is MOV (1101) or MVN (1111).
  - Rm=[3:0] is used when [27:25]=000 (register operand) or [27:25]=011 (register-offset load/store).
  - Rd=[15:12] is also a source for stores: [27:26]=01 and L bit [20]=0.
- hazard = ID_valid & EXE_valid & EXE_load & EXE_Rd_num!=PC_REG & (EXE_Rd_num matches any used source).
- FSM states: RUN, STALL.
  - RUN & hazard & !branch_taken: PC_enable=0 and ID_EXE_bubble=1 combinationally. IF/ID holds. Next state is STALL.
  - STALL: exactly one cycle. Hazard is ignored, PC_enable=1, ID_EXE_bubble=0, IF/ID loads IF_*. Next state is RUN. The load is now in MEM and forwarding covers it.
  - RUN & !hazard: IF/ID loads IF_instruction, IF_PC, IF_valid every cycle (latency 1).
- branch_taken has priority over hazard and over STALL.
  - On the next edge: ID_valid=0, ID_instruction=0, ID_PC held, state=RUN.
  - Same cycle: PC_enable=1 (fetch redirect), ID_EXE_bubble=1 (squash the wrong-path ID instruction).
- Priority: reset > branch_taken > hazard/STALL > normal load.
- IF_valid=0 loads ID_valid=0. An invalid ID slot never raises hazard.
- Reset asserted mid-stall returns to RUN with cleared outputs. No stall carries over.
- Back-to-back loads each give at most one stall cycle. A hazard cannot re-trigger in STALL because EXE holds the bubble.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - Adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - stall_cnt increments on each RUN→STALL transition; flush_cnt increments on each branch_taken cycle.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - State encoding (RUN=1'b0, STALL=1'b1).
  - I_cmd constants (DP_REG=3'b000, DP_IMM=3'b001, LS_IMM=3'b010, LS_REG=3'b011, BRANCH=3'b101).
  - Opcode constants MOV=4'b1101, MVN=4'b1111.
  - PC_REG=4'd15 and NOP instruction=32'h0.
- One natural sub-module: src_reg_decode, combinational. Takes the instruction and returns Rn/Rm/Rd numbers plus use flags. It is reused later by the forwarding unit.

Test Plan:
- Load-use via Rn: EXE_load=1, EXE_valid=1, EXE_Rd_num=3, ID ADD r1,r3,r2 (0xE0831002) → PC_enable=0, ID_EXE_bubble=1 for one cycle, stalled=1 next cycle. ID_instruction holds 0xE0831002 for 2 cycles.
- No false hazard: same load in EXE, ID MOV r1,r3 (0xE1A01003, Rn field 0) with EXE_Rd_num=0 → no stall. Repeat with EXE_Rd_num=15 and a matching source → no stall.
- Store data hazard: EXE load to r5, ID STR r5,[r0] (0xE5805000) → one-cycle stall.
- Branch flush during stall: hazard cycle with branch_taken=1 → PC_enable=1, ID_EXE_bubble=1. Next edge ID_valid=0, state=RUN.
- Reset mid-STALL: reset=1 in STALL → next edge outputs zero, state RUN. After release with IF_valid=1, IF_instruction=0xE2811001, ID_instruction=0xE2811001 one cycle later.
- HAZARD_STATS_EN: 3 load-use stalls and 2 branches → stall_cnt=3, flush_cnt=2. Force stall_cnt=16'hFFFF, add a stall → remains 16'hFFFF.
